// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dm_arbiter
// Brief   : Two-port data-memory arbiter (CPU MEM stage vs loader/debug port).
//           Optional round-robin policy via DM_ARB_ROUND_ROBIN_EN.
// Revision: 1.0
// ============================================================================
module dm_arbiter #(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_LIMIT = 1024,
    parameter int MAX_WAIT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [BIT_WIDTH-1:0] addr0,
    input  logic [BIT_WIDTH-1:0] addr1,
    input  logic [BIT_WIDTH-1:0] wdata0,
    input  logic [BIT_WIDTH-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [BIT_WIDTH-1:0] rdata0,
    output logic [BIT_WIDTH-1:0] rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic [BIT_WIDTH-1:0] dm_addr,
    output logic [BIT_WIDTH-1:0] dm_din,
    output logic                 dm_wr,
    input  logic [BIT_WIDTH-1:0] dm_dout
);

    localparam int                   WAIT_W       = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]    C_WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [BIT_WIDTH-1:0] C_ADDR_LIMIT = BIT_WIDTH'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e            r_rd_owner;
    logic              r_rd_oob;
    logic              r_err0;
    logic              r_err1;
    logic [WAIT_W-1:0] r_wait1;

    logic                 w_force1;
    logic                 w_sel1;
    logic                 w_we;
    logic                 w_in_range;
    logic [BIT_WIDTH-1:0] w_addr;
    logic [BIT_WIDTH-1:0] w_din;

    assign w_force1 = req1 && (r_wait1 == C_WAIT_MAX);

`ifdef DM_ARB_ROUND_ROBIN_EN
    // Port that gets the next tie; flips to the loser of every grant.
    logic r_prio1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (gnt0 || gnt1) begin
            r_prio1 <= gnt0;
        end
    end

    assign w_sel1 = req1 && (!req0 || w_force1 || r_prio1);
`else
    assign w_sel1 = req1 && (!req0 || w_force1);
`endif

    // Grants are masked while reset is held so the DM sees no access.
    assign gnt1 = rst_n && w_sel1;
    assign gnt0 = rst_n && req0 && !w_sel1;

    always_comb begin
        w_addr = '0;
        w_din  = '0;
        w_we   = 1'b0;
        if (gnt1) begin
            w_addr = addr1;
            w_din  = wdata1;
            w_we   = we1;
        end else if (gnt0) begin
            w_addr = addr0;
            w_din  = wdata0;
            w_we   = we0;
        end
    end

    assign w_in_range = (w_addr < C_ADDR_LIMIT);
    assign dm_addr    = w_addr;
    assign dm_din     = w_din;
    assign dm_wr      = w_we && w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_owner <= OWN_NONE;
            r_rd_oob   <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_wait1    <= '0;
        end else begin
            r_rd_owner <= OWN_NONE;
            r_rd_oob   <= 1'b0;
            r_err0     <= gnt0 && !w_in_range;
            r_err1     <= gnt1 && !w_in_range;
            if ((gnt0 || gnt1) && !w_we) begin
                r_rd_owner <= gnt1 ? OWN_P1 : OWN_P0;
                r_rd_oob   <= !w_in_range;
            end
            if (!req1 || gnt1) begin
                r_wait1 <= '0;
            end else if (r_wait1 != C_WAIT_MAX) begin
                r_wait1 <= r_wait1 + WAIT_W'(1);
            end
        end
    end

    assign rvalid0 = (r_rd_owner == OWN_P0);
    assign rvalid1 = (r_rd_owner == OWN_P1);
    assign rdata0  = (rvalid0 && !r_rd_oob) ? dm_dout : '0;
    assign rdata1  = (rvalid1 && !r_rd_oob) ? dm_dout : '0;
    assign err0    = r_err0;
    assign err1    = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dm_arbiter
// Brief   : Self-checking bench for dm_arbiter with a DM model and a
//           transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_dm_arbiter;

    localparam int BW  = 32;
    localparam int LIM = 1024;
    localparam int MW  = 4;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [BW-1:0] addr0, addr1, wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [BW-1:0] rdata0, rdata1;
    logic [BW-1:0] dm_addr, dm_din, dm_dout;
    logic          dm_wr;
    logic          dm_clear;

    int n_tests = 0;
    int n_fail  = 0;

    dm_arbiter #(.BIT_WIDTH(BW), .ADDR_LIMIT(LIM), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: registered read, synchronous write.
    logic [BW-1:0] dm_mem [0:LIM-1];
    always @(posedge clk) begin
        if (dm_clear) begin
            for (int i = 0; i < LIM; i++) dm_mem[i] <= '0;
            dm_dout <= '0;
        end else begin
            if (dm_wr && dm_addr < LIM) dm_mem[dm_addr[9:0]] <= dm_din;
            dm_dout <= (dm_addr < LIM) ? dm_mem[dm_addr[9:0]] : 32'hBAD0_BAD0;
        end
    end

    // Reference model state.
    logic [BW-1:0] ref_mem [0:LIM-1];
    int            m_wait, m_rr, m_owner;
    logic          m_oob, m_err0, m_err1;
    logic [BW-1:0] m_data;

    task automatic model_reset();
        m_wait = 0; m_rr = 0; m_owner = -1;
        m_oob = 1'b0; m_err0 = 1'b0; m_err1 = 1'b0; m_data = '0;
    endtask

    function automatic int exp_winner();
        if (!rst_n) return -1;
        if (req1 && m_wait >= MW) return 1;
`ifdef DM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) return m_rr;
`endif
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    function automatic logic [66:0] exp_comb();
        int w;
        logic [BW-1:0] a, d;
        logic wv;
        w = exp_winner();
        if (w < 0) return '0;
        a  = (w == 1) ? addr1 : addr0;
        d  = (w == 1) ? wdata1 : wdata0;
        wv = (w == 1) ? we1 : we0;
        return {w == 0, w == 1, wv && (a < LIM), a, d};
    endfunction

    function automatic logic [67:0] exp_reg();
        logic [BW-1:0] d0, d1;
        d0 = (m_owner == 0 && !m_oob) ? m_data : '0;
        d1 = (m_owner == 1 && !m_oob) ? m_data : '0;
        return {m_owner == 0, d0, m_err0, m_owner == 1, d1, m_err1};
    endfunction

    // Advance one clock; the model applies the access the arbiter should grant.
    task automatic tick();
        int w;
        logic [BW-1:0] a, d;
        logic wv, inr, r1;
        w   = exp_winner();
        a   = (w == 1) ? addr1 : addr0;
        d   = (w == 1) ? wdata1 : wdata0;
        wv  = (w == 1) ? we1 : we0;
        inr = (a < LIM);
        r1  = req1;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_err0 = 1'b0; m_err1 = 1'b0; m_owner = -1; m_oob = 1'b0; m_data = '0;
            if (w >= 0) begin
                if (!inr) begin
                    if (w == 0) m_err0 = 1'b1; else m_err1 = 1'b1;
                end
                if (!wv) begin
                    m_owner = w;
                    m_oob   = !inr;
                    m_data  = inr ? ref_mem[a[9:0]] : '0;
                end else if (inr) begin
                    ref_mem[a[9:0]] = d;
                end
                m_rr = 1 - w;
            end
            m_wait = (r1 && w != 1) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        #1;
        n_tests++;
        if ({gnt0, gnt1, dm_wr, dm_addr, dm_din, rvalid0, rdata0, err0, rvalid1, rdata1, err1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b%b dm_wr=%b dm_addr=%h rvalid=%b%b, required all 0",
                     gnt0, gnt1, dm_wr, dm_addr, rvalid0, rvalid1);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({gnt0, gnt1, dm_addr} !== {2'b10, 32'd5}) begin
            n_fail++;
            $display("FAIL reset_release_grant: gnt=%b%b dm_addr=%h, required 10 / 5", gnt0, gnt1, dm_addr);
        end
        tick();
        req0 = 1'b0;
        #1;
        n_tests++;
        if (rvalid0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read_inflight: rvalid0=%b, required 1", rvalid0);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({rvalid0, rdata0, err0, rvalid1, rdata1, err1, gnt0, gnt1} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_read: rvalid=%b%b err=%b%b, required 0", rvalid0, rvalid1, err0, err1);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({rvalid0, rvalid1, rdata0} !== '0) begin
            n_fail++;
            $display("FAIL reset_no_rvalid_after: rvalid=%b%b rdata0=%h, required 0", rvalid0, rvalid1, rdata0);
        end
    endtask

    task automatic test_single_read();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if ({gnt0, gnt1, dm_wr, dm_addr, dm_din} !== {3'b011, 32'd7, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL single_write_grant: gnt=%b%b wr=%b addr=%h din=%h, required 01 1 7 deadbeef",
                     gnt0, gnt1, dm_wr, dm_addr, dm_din);
        end
        tick();
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd7;
        #1;
        n_tests++;
        if ({gnt0, gnt1, dm_wr, rvalid1} !== 4'b1000) begin
            n_fail++;
            $display("FAIL single_read_grant: gnt=%b%b wr=%b rvalid1=%b, required 10 0 0", gnt0, gnt1, dm_wr, rvalid1);
        end
        tick();
        req0 = 1'b0;
        #1;
        n_tests++;
        if ({rvalid0, rdata0, rvalid1, err0} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
            n_fail++;
            $display("FAIL single_read_data: rvalid0=%b rdata0=%h rvalid1=%b, required 1 deadbeef 0",
                     rvalid0, rdata0, rvalid1);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic e1;
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        for (int k = 0; k < 15; k++) begin
            #1;
`ifdef DM_ARB_ROUND_ROBIN_EN
            e1 = (k % 2 == 1);
`else
            e1 = (k % (MW + 1) == MW);
`endif
            n_tests++;
            if ({gnt0, gnt1} !== {~e1, e1}) begin
                n_fail++;
                $display("FAIL conflict_cycle%0d: gnt=%b%b, required %b%b", k, gnt0, gnt1, ~e1, e1);
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd1024; wdata1 = 32'h1;
        #1;
        n_tests++;
        if ({gnt0, gnt1, dm_wr} !== 3'b010) begin
            n_fail++;
            $display("FAIL oob_write_grant: gnt=%b%b dm_wr=%b, required 01 0", gnt0, gnt1, dm_wr);
        end
        tick();
        we1 = 1'b0; addr1 = 32'd2000;
        #1;
        n_tests++;
        if ({err1, rvalid1, err0, gnt1} !== 4'b1001) begin
            n_fail++;
            $display("FAIL oob_write_err: err1=%b rvalid1=%b err0=%b gnt1=%b, required 1 0 0 1",
                     err1, rvalid1, err0, gnt1);
        end
        tick();
        req1 = 1'b0;
        #1;
        n_tests++;
        if ({rvalid1, rdata1, err1} !== {1'b1, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL oob_read: rvalid1=%b rdata1=%h err1=%b, required 1 0 1", rvalid1, rdata1, err1);
        end
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd1023; wdata0 = 32'hA5A5_5A5A;
        #1;
        n_tests++;
        if ({err1, rvalid1, gnt0, dm_wr} !== 4'b0011) begin
            n_fail++;
            $display("FAIL edge_write: err1=%b rvalid1=%b gnt0=%b dm_wr=%b, required 0 0 1 1",
                     err1, rvalid1, gnt0, dm_wr);
        end
        tick();
        we0 = 1'b0;
        tick();
        req0 = 1'b0;
        #1;
        n_tests++;
        if ({rvalid0, rdata0, err0} !== {1'b1, 32'hA5A5_5A5A, 1'b0}) begin
            n_fail++;
            $display("FAIL edge_read: rvalid0=%b rdata0=%h err0=%b, required 1 a5a55a5a 0", rvalid0, rdata0, err0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            req1 = 1'b1; we1 = 1'b1; addr1 = 32'(i); wdata1 = 32'h100 + 32'(i);
            tick();
        end
        req1 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0 = (i < 3); we0 = 1'b0; addr0 = 32'(i);
            #1;
            n_tests++;
            if (gnt0 !== (i < 3)) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: gnt0=%b, required %b", i, gnt0, (i < 3));
            end
            if (i > 0) begin
                n_tests++;
                if ({rvalid0, rdata0} !== {1'b1, 32'h100 + 32'(i - 1)}) begin
                    n_fail++;
                    $display("FAIL b2b_data%0d: rvalid0=%b rdata0=%h, required 1 %h",
                             i - 1, rvalid0, rdata0, 32'h100 + 32'(i - 1));
                end
            end
            tick();
        end
    endtask

    function automatic logic [BW-1:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 32'(LIM + $urandom_range(0, 4000));
        return 32'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        logic pend0, pend1;
        logic [66:0] ec;
        logic [67:0] er;
        int w;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!pend0) begin
                req0 = ($urandom_range(0, 9) < 6);
                we0 = 1'($urandom_range(0, 1)); addr0 = pick_addr(); wdata0 = $urandom;
                pend0 = req0;
            end
            if (!pend1) begin
                req1 = ($urandom_range(0, 9) < 6);
                we1 = 1'($urandom_range(0, 1)); addr1 = pick_addr(); wdata1 = $urandom;
                pend1 = req1;
            end
            #1;
            ec = exp_comb();
            er = exp_reg();
            n_tests++;
            if ({gnt0, gnt1, dm_wr, dm_addr, dm_din} !== ec) begin
                n_fail++;
                $display("FAIL rand_comb%0d: gnt/wr/addr/din=%h, required %h", k,
                         {gnt0, gnt1, dm_wr, dm_addr, dm_din}, ec);
            end
            n_tests++;
            if ({rvalid0, rdata0, err0, rvalid1, rdata1, err1} !== er) begin
                n_fail++;
                $display("FAIL rand_read%0d: rvalid/rdata/err=%h, required %h", k,
                         {rvalid0, rdata0, err0, rvalid1, rdata1, err1}, er);
            end
            w = exp_winner();
            tick();
            if (w == 0) pend0 = 1'b0;
            if (w == 1) pend1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; dm_clear = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < LIM; i++) ref_mem[i] = '0;
        model_reset();
        @(posedge clk);
        dm_clear = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_conflict();
        test_out_of_range();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter that shares the single data memory (DM: 1-cycle registered read, synchronous write, word-addressed) between the CPU memory stage (port 0) and the program/data loader or debug port (port 1). It grants at most one access per cycle, drives the DM address/data/write lines, returns read data with a valid strobe to the owning requester, and guards against starvation and out-of-range addresses. It sits between the MEM pipeline stage / loader and the DM instance.

## Interface
- BIT_WIDTH, 32, data and address width
- ADDR_LIMIT, 1024, number of DM words; valid addresses are 0..ADDR_LIMIT-1
- MAX_WAIT, 4, consecutive denied cycles after which port 1 is forced to win

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  BIT_WIDTH  word address
- wdata0 / wdata1  in  BIT_WIDTH  write data
- gnt0 / gnt1  out  1  combinational; access accepted at this rising edge
- rvalid0 / rvalid1  out  1  read data valid this cycle
- rdata0 / rdata1  out  BIT_WIDTH  read data, 0 when rvalid low
- err0 / err1  out  1  1-cycle pulse: previously granted access was out of range
- dm_addr  out  BIT_WIDTH  to DM addr
- dm_din  out  BIT_WIDTH  to DM Data_In
- dm_wr  out  1  to DM WR
- dm_dout  in  BIT_WIDTH  from DM Data_Out

## Operation
- Per cycle, winner chosen combinationally from req0, req1 and state; at most one of gnt0/gnt1 high.
- Default policy: fixed priority, port 0 over port 1.
- Starvation guard: wait1 counter (width ≥ clog2(MAX_WAIT+1)) increments each cycle req1 high and gnt1 low; clears on gnt1 or req1 low. When wait1 == MAX_WAIT and req1 high, port 1 wins even if req0 high; wait1 saturates, never wraps.
- Winner's addr/wdata drive dm_addr/dm_din; dm_wr = winner.we & in-range. No winner: dm_wr = 0, dm_addr/dm_din = 0.
- Range check: addr ≥ ADDR_LIMIT → access still granted (requester not stalled forever), dm_wr forced 0, next cycle errX = 1, rvalidX = 1 if read with rdataX = 0.
- Read return: registered rd_owner (none/0/1) and rd_oob set at grant of a read; next cycle rvalid of that owner = 1, rdata = dm_dout (or 0 if rd_oob). Writes produce no rvalid.
- Requesters must keep req/we/addr/wdata stable until gnt; may deassert req the cycle after gnt or re-request immediately (back-to-back accesses, one per cycle).

## Timing
- Reset (rst_n low, any time): gnt0/1 = 0, dm_wr = 0, dm_addr = dm_din = 0, rvalid0/1 = 0, rdata0/1 = 0, err0/1 = 0, wait1 = 0, rd_owner = none, RR pointer = port 0. Reset during an outstanding read drops it: no rvalid after release.
- Grant latency: 0 cycles (same cycle as req when winning).
- Read latency: rvalid exactly 1 cycle after the granted edge.
- Write committed to DM at the granted edge; a read granted the following cycle (either port) returns the new value.
- Throughput: 1 access/cycle sustained.

## Configuration
- DM_ARB_ROUND_ROBIN_EN defined: policy is round-robin; 1-bit last-winner pointer updated on every grant; on simultaneous requests the port that did not win last wins. Starvation counter still present but never reaches MAX_WAIT ≥ 2.
- Undefined: fixed priority port 0 with starvation guard as above.

## Test plan
- Reset: assert rst_n low mid-read of addr 5 → all outputs 0, no rvalid after release; wait1 = 0.
- Single read: write 0xDEADBEEF to addr 7 via port 1, next cycle port 0 reads addr 7 → gnt0 same cycle, rvalid0 = 1 with rdata0 = 0xDEADBEEF one cycle later, rvalid1 stays 0.
- Conflict (fixed): req0 and req1 held high continuously, MAX_WAIT = 4 → gnt0 for 4 cycles, gnt1 on 5th, pattern repeats; wait1 never exceeds 4.
- Out of range: port 1 writes addr 1024 with data 0x1 → gnt1 = 1, dm_wr = 0, err1 pulse next cycle; read of addr 2000 → rvalid1 = 1, rdata1 = 0, err1 = 1.
- Back-to-back: port 0 reads addrs 0,1,2 on consecutive cycles → rvalid0 three consecutive cycles with matching data.
- DM_ARB_ROUND_ROBIN_EN: both ports requesting continuously → gnt alternates 0,1,0,1 starting with port 0 after reset.
